adc_decimator: RTL and testbench

- Conditioning stage directly upstream of the PDH core's ADC AXIS input.
- Takes raw 125 MS/s dual-channel ADC words, sign-extends each 14-bit sample and box-car averages 2^N samples per channel.
- Emits one averaged dual-channel word per window on an AXIS-style valid-only stream with the same packing the core expects.
- Also reports per-window ADC over-range flags.

---
 rtl/adc_decimator.sv | 154 +++++++++++++++
 tb/tb_adc_decimator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/adc_decimator.sv
// Box-car decimator for the dual-channel 14-bit ADC stream feeding the PDH core.
// Ports: clk, rst_ni (async low), en_i, dec_log2_i (N), adc_tdata_i/adc_tvalid_i
//   raw samples (ch1 [15:0], ch2 [31:16]), offset1_i/offset2_i (signed DC
//   offsets), m_tdata_o/m_tvalid_o averaged output pulse, ovr_o per-window
//   over-range flags (bit0 ch1, bit1 ch2).
// Optional: define ADC_DECIMATOR_DC_OFFSET_EN to subtract saturated offsets.
module adc_decimator #(
    parameter int ADC_DATA_WIDTH   = 16,
    parameter int ADC_BITS         = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int MAX_DEC_LOG2     = 8,
    parameter int ACC_WIDTH        = 24
) (
    input  logic                        clk,
    input  logic                        rst_ni,
    input  logic                        en_i,
    input  logic [3:0]                  dec_log2_i,
    input  logic [AXIS_TDATA_WIDTH-1:0] adc_tdata_i,
    input  logic                        adc_tvalid_i,
    input  logic [ADC_DATA_WIDTH-1:0]   offset1_i,
    input  logic [ADC_DATA_WIDTH-1:0]   offset2_i,
    output logic [AXIS_TDATA_WIDTH-1:0] m_tdata_o,
    output logic                        m_tvalid_o,
    output logic [1:0]                  ovr_o
);

    localparam int DW = ADC_DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int CW = MAX_DEC_LOG2 + 1;
    localparam logic signed [AW-1:0] SMAX =
        AW'((1 << (ADC_BITS - 1)) - 1);
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t state_q, state_d;

    logic signed [AW-1:0] acc1_q, acc2_q;
    logic signed [AW-1:0] s1, s2;
    logic signed [AW-1:0] sum1, sum2;
    logic signed [AW-1:0] sh1, sh2;
    logic [CW-1:0]        cnt_q, win_last;
    logic [3:0]           n_q, n_clamp;
    logic [1:0]           flag_q, or_now;
    logic [ADC_BITS-1:0]  raw1, raw2;
    logic                 take, done;

    function automatic logic signed [AW-1:0] sext(
        input logic [ADC_BITS-1:0] r
    );
        return {{(AW-ADC_BITS){r[ADC_BITS-1]}}, r};
    endfunction

    function automatic logic is_ovr(input logic [ADC_BITS-1:0] r);
        return (r == {1'b1, {(ADC_BITS-1){1'b0}}}) ||
               (r == {1'b0, {(ADC_BITS-1){1'b1}}});
    endfunction

    assign raw1 = adc_tdata_i[ADC_BITS-1:0];
    assign raw2 = adc_tdata_i[DW+ADC_BITS-1:DW];

`ifdef ADC_DECIMATOR_DC_OFFSET_EN
    function automatic logic signed [AW-1:0] sub_sat(
        input logic [ADC_BITS-1:0] r,
        input logic [DW-1:0]       off
    );
        logic signed [AW-1:0] d;
        d = sext(r) - {{(AW-DW){off[DW-1]}}, off};
        if (d > SMAX)
            d = SMAX;
        else if (d < SMIN)
            d = SMIN;
        return d;
    endfunction

    assign s1 = sub_sat(raw1, offset1_i);
    assign s2 = sub_sat(raw2, offset2_i);

    logic unused_bits;
    assign unused_bits = ^{adc_tdata_i[DW-1:ADC_BITS],
                           adc_tdata_i[2*DW-1:DW+ADC_BITS],
                           sh1[AW-1:DW], sh2[AW-1:DW]};
`else
    assign s1 = sext(raw1);
    assign s2 = sext(raw2);

    logic unused_bits;
    assign unused_bits = ^{adc_tdata_i[DW-1:ADC_BITS],
                           adc_tdata_i[2*DW-1:DW+ADC_BITS],
                           sh1[AW-1:DW], sh2[AW-1:DW],
                           offset1_i, offset2_i, SMIN};
`endif

    assign or_now   = {is_ovr(raw2), is_ovr(raw1)};
    assign n_clamp  = (dec_log2_i > 4'(MAX_DEC_LOG2)) ?
                      4'(MAX_DEC_LOG2) : dec_log2_i;
    assign win_last = (CW'(1) << n_q) - CW'(1);
    assign take     = (state_q == ACCUM) && en_i && adc_tvalid_i;
    assign done     = take && (cnt_q == win_last);
    assign sum1     = acc1_q + s1;
    assign sum2     = acc2_q + s2;
    assign sh1      = sum1 >>> n_q;
    assign sh2      = sum2 >>> n_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en_i)  state_d = ACCUM;
            ACCUM:   if (!en_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            n_q        <= '0;
            cnt_q      <= '0;
            acc1_q     <= '0;
            acc2_q     <= '0;
            flag_q     <= '0;
            m_tdata_o  <= '0;
            m_tvalid_o <= 1'b0;
            ovr_o      <= '0;
        end else begin
            state_q    <= state_d;
            m_tvalid_o <= 1'b0;
            if (state_q == IDLE || !en_i) begin
                // Idle or leaving: drop any partial window.
                cnt_q  <= '0;
                acc1_q <= '0;
                acc2_q <= '0;
                flag_q <= '0;
                if (state_q == IDLE && en_i)
                    n_q <= n_clamp;
            end else if (done) begin
                m_tdata_o  <= {sh2[DW-1:0], sh1[DW-1:0]};
                m_tvalid_o <= 1'b1;
                ovr_o      <= flag_q | or_now;
                cnt_q      <= '0;
                acc1_q     <= '0;
                acc2_q     <= '0;
                flag_q     <= '0;
                n_q        <= n_clamp;
            end else if (take) begin
                cnt_q  <= cnt_q + CW'(1);
                acc1_q <= sum1;
                acc2_q <= sum2;
                flag_q <= flag_q | or_now;
            end
        end
    end

endmodule

// File: tb/tb_adc_decimator.sv
// Directed bench for adc_decimator.
// Drives at negedge, checks at negedge, counts output pulses in a monitor.
module tb_adc_decimator;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic [3:0]  dec_log2_i;
    logic [31:0] adc_tdata_i;
    logic        adc_tvalid_i;
    logic [15:0] offset1_i;
    logic [15:0] offset2_i;
    logic [31:0] m_tdata_o;
    logic        m_tvalid_o;
    logic [1:0]  ovr_o;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    int p0;

    always #4 clk = ~clk;

    adc_decimator dut (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .dec_log2_i   (dec_log2_i),
        .adc_tdata_i  (adc_tdata_i),
        .adc_tvalid_i (adc_tvalid_i),
        .offset1_i    (offset1_i),
        .offset2_i    (offset2_i),
        .m_tdata_o    (m_tdata_o),
        .m_tvalid_o   (m_tvalid_o),
        .ovr_o        (ovr_o)
    );

    always @(posedge clk) begin
        #2;
        if (m_tvalid_o) pulses++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [3:0] n);
        @(negedge clk);
        en_i = 1'b0;
        @(negedge clk);
        en_i = 1'b1;
        dec_log2_i = n;
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] c1, input logic [15:0] c2);
        adc_tdata_i  = {c2, c1};
        adc_tvalid_i = 1'b1;
        @(negedge clk);
        adc_tvalid_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        en_i = 1'b0;
        dec_log2_i = '0;
        adc_tdata_i = '0;
        adc_tvalid_i = 1'b0;
        offset1_i = '0;
        offset2_i = '0;
        #1;
        check("rst_data", m_tdata_o, 32'h0);
        check("rst_valid", {31'h0, m_tvalid_o}, 32'h0);
        check("rst_ovr", {30'h0, ovr_o}, 32'h0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // N=2 with floor rounding on negative lane
        start(4'd2);
        p0 = pulses;
        push(16'd10, 16'hFFFF);
        push(16'd11, 16'hFFFE);
        push(16'd12, 16'hFFFD);
        check("n2_novalid", {31'h0, m_tvalid_o}, 32'h0);
        push(16'd13, 16'hFFFC);
        check("n2_valid", {31'h0, m_tvalid_o}, 32'h1);
        check("n2_data", m_tdata_o, 32'hFFFD_000B);
        check("n2_ovr", {30'h0, ovr_o}, 32'h0);
        @(negedge clk);
        check("n2_width", {31'h0, m_tvalid_o}, 32'h0);
        check("n2_hold", m_tdata_o, 32'hFFFD_000B);
        check("n2_pulses", pulses - p0, 32'd1);

        // N=0 continuous, lane bits [15:14] ignored
        start(4'd0);
        for (int i = 0; i < 6; i++) begin
            adc_tdata_i  = {16'(i * 7), 16'hFFFF};
            adc_tvalid_i = 1'b1;
            @(negedge clk);
            check("n0_valid", {31'h0, m_tvalid_o}, 32'h1);
            check("n0_data", m_tdata_o, {16'(i * 7), 16'hFFFF});
        end
        adc_tvalid_i = 1'b0;
        @(negedge clk);
        check("n0_stop", {31'h0, m_tvalid_o}, 32'h0);

        // Async reset mid-window
        start(4'd3);
        repeat (5) push(16'd100, 16'd100);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_data", m_tdata_o, 32'h0);
        check("arst_valid", {31'h0, m_tvalid_o}, 32'h0);
        check("arst_ovr", {30'h0, ovr_o}, 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        en_i = 1'b0;
        start(4'd3);
        p0 = pulses;
        repeat (8) push(16'd100, 16'd100);
        check("arst_win_valid", {31'h0, m_tvalid_o}, 32'h1);
        check("arst_win_data", m_tdata_o, 32'h0064_0064);
        @(negedge clk);
        check("arst_pulses", pulses - p0, 32'd1);

        // N=8, valid every third clock, full-scale positive
        start(4'd8);
        p0 = pulses;
        for (int i = 0; i < 256; i++) begin
            push(16'd8191, 16'd8191);
            if (i < 255) repeat (2) @(negedge clk);
        end
        check("gap_valid", {31'h0, m_tvalid_o}, 32'h1);
        check("gap_data", m_tdata_o, 32'h1FFF_1FFF);
        check("gap_ovr", {30'h0, ovr_o}, 32'h3);
        @(negedge clk);
        check("gap_pulses", pulses - p0, 32'd1);

        // Mid-window exponent change applies to the next window
        start(4'd2);
        push(16'd1, 16'd0);
        push(16'd2, 16'd0);
        dec_log2_i = 4'd1;
        push(16'd3, 16'd0);
        check("dchg_novalid", {31'h0, m_tvalid_o}, 32'h0);
        push(16'd6, 16'd0);
        check("dchg_w1_valid", {31'h0, m_tvalid_o}, 32'h1);
        check("dchg_w1_data", m_tdata_o, 32'h0000_0003);
        push(16'd5, 16'd0);
        check("dchg_w2_novalid", {31'h0, m_tvalid_o}, 32'h0);
        push(16'd8, 16'd0);
        check("dchg_w2_valid", {31'h0, m_tvalid_o}, 32'h1);
        check("dchg_w2_data", m_tdata_o, 32'h0000_0006);

        // Exponent 15 clamps to 256-sample windows
        start(4'd15);
        p0 = pulses;
        repeat (255) push(16'd2, 16'hFFFE);
        @(negedge clk);
        check("clamp_early", pulses - p0, 32'd0);
        push(16'd2, 16'hFFFE);
        check("clamp_valid", {31'h0, m_tvalid_o}, 32'h1);
        check("clamp_data", m_tdata_o, 32'hFFFE_0002);

        // DC offset feature
        offset1_i = 16'd100;
        start(4'd1);
        push(16'd50, 16'd0);
        push(16'd50, 16'd0);
        check("off_valid", {31'h0, m_tvalid_o}, 32'h1);
`ifdef ADC_DECIMATOR_DC_OFFSET_EN
        check("off_sub", m_tdata_o, 32'h0000_FFCE);
        offset1_i = 16'hFF9C;
        start(4'd0);
        push(16'd8150, 16'd0);
        check("off_sat", m_tdata_o, 32'h0000_1FFF);
        check("off_ovr", {30'h0, ovr_o}, 32'h0);
`else
        check("off_ignored", m_tdata_o, 32'h0000_0032);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
